pe_col_drain: RTL and testbench

// Drain for one PE-array column. Captures a programmed burst of ACC_BW accumulator results from
// the bottom PE's o_o, then rounds and saturates each to MUL_BW fixed point (FRA_BW frac bits).

---
 rtl/pe_col_drain.sv | 133 +++++++++++++
 tb/tb_pe_col_drain.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_col_drain.sv
// Column drain: windowed capture of accumulator results, round/saturate
// to fixed point, and a show-ahead FIFO toward a valid/ready consumer.
module pe_col_drain #(
    parameter int INT_BW = 5,
    parameter int FRA_BW = 7,
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_BW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        skip,
    input  logic [CNT_BW-1:0] len,
    input  logic [ACC_BW-1:0] acc_i,
    output logic [MUL_BW-1:0] out_data,
    output logic              out_sat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LIM = 1 << (INT_BW + FRA_BW);
    localparam logic signed [ACC_BW-1:0] SMAX = ACC_BW'(LIM - 1);
    localparam logic signed [ACC_BW-1:0] SMIN = ACC_BW'(-LIM);

    typedef enum logic [1:0] {IDLE, SKIP, CAPT, FLUSH} state_t;

    state_t              state, state_n;
    logic                accept;
    logic [CNT_BW-1:0]   cnt, len_r;
    logic [AW:0]         wr_ptr, rd_ptr;
    logic [MUL_BW:0]     mem [DEPTH];
    logic [MUL_BW:0]     head;
    logic                empty, full, pop, capt, push, drop;
    logic signed [ACC_BW-1:0] s;
    logic [MUL_BW-1:0]   cv_data;
    logic                cv_sat;

    // Floor-shift away the extra fraction bits, then clamp to the output range
    assign s = $signed(acc_i) >>> FRA_BW;

    always_comb begin
        cv_sat  = 1'b0;
        cv_data = s[MUL_BW-1:0];
        if (s > SMAX) begin
            cv_sat  = 1'b1;
            cv_data = SMAX[MUL_BW-1:0];
        end else if (s < SMIN) begin
            cv_sat  = 1'b1;
            cv_data = SMIN[MUL_BW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (len == '0)       state_n = FLUSH;
                    else if (skip == '0) state_n = CAPT;
                    else                 state_n = SKIP;
                end
            end
            SKIP:  if (cnt == CNT_BW'(1)) state_n = CAPT;
            CAPT:  if (cnt == CNT_BW'(1)) state_n = FLUSH;
            FLUSH: if (empty) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == FLUSH) && empty;
    assign capt = (state == CAPT);

    // cnt holds remaining skip cycles in SKIP and remaining samples in CAPT
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            len_r <= '0;
            ovf   <= 1'b0;
        end else begin
            if (accept) begin
                cnt   <= (skip == '0) ? len : CNT_BW'(skip);
                len_r <= len;
                ovf   <= 1'b0;
            end else if (state == SKIP) begin
                cnt <= (cnt == CNT_BW'(1)) ? len_r : cnt - 1'b1;
            end else if (capt) begin
                cnt <= cnt - 1'b1;
            end
            if (drop) ovf <= 1'b1;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = out_valid && out_ready;
    assign push  = capt && (!full || pop);
    assign drop  = capt && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {cv_sat, cv_data};
    end

    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_valid = !empty;
    assign out_data  = out_valid ? head[MUL_BW-1:0] : '0;
    assign out_sat   = out_valid && head[MUL_BW];

endmodule

// File: tb/tb_pe_col_drain.sv
// Bench for pe_col_drain: conversion table, hand-timed bursts and a
// randomized run against a cycle-window/queue reference model.
module tb_pe_col_drain;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, start, out_ready;
    logic [7:0]  skip;
    logic [15:0] len;
    logic [31:0] acc_i;
    logic [15:0] out_data;
    logic        out_sat, out_valid, busy, done, ovf;

    always #5 clk = ~clk;

    pe_col_drain dut (
        .clk(clk), .rst(rst), .start(start), .skip(skip), .len(len),
        .acc_i(acc_i), .out_data(out_data), .out_sat(out_sat),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .done(done), .ovf(ovf)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // Reference: value = floor(acc / 2^7) clamped to [-4096, 4095]
    function automatic logic [16:0] conv(input logic [31:0] a);
        longint v;
        v = longint'($signed(a)) >>> 7;
        if (v > 4095)  return {1'b1, 16'h0FFF};
        if (v < -4096) return {1'b1, 16'hF000};
        return {1'b0, 16'(v)};
    endfunction

    // Model: burst described by start cycle and window, FIFO as a queue
    int          cyc = 0;
    int          t0 = 0, mskip = 0, mlen = 0;
    bit          mbusy = 0, mdone = 0, movf = 0;
    logic [16:0] mq[$];

    task automatic tick();
        bit pop, capt;
        int fs;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mbusy = 0;
            movf  = 0;
        end else begin
            pop  = (mq.size() > 0) && out_ready;
            capt = mbusy && mlen > 0 && cyc >= t0 + 1 + mskip &&
                   cyc <= t0 + mskip + mlen;
            if (pop) void'(mq.pop_front());
            if (capt) begin
                if (mq.size() < DEPTH) mq.push_back(conv(acc_i));
                else movf = 1;
            end
            if (mdone) mbusy = 0;
            else if (!mbusy && start) begin
                mbusy = 1; t0 = cyc; mskip = skip; mlen = len; movf = 0;
            end
        end
        cyc++;
        fs    = (mlen == 0) ? t0 + 1 : t0 + mskip + mlen + 1;
        mdone = mbusy && cyc >= fs && mq.size() == 0;
        #1;
        chk("m_valid", out_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("m_data", out_data, mq[0][15:0]);
            chk("m_sat", out_sat, mq[0][16]);
        end
        chk("m_busy", busy, mbusy);
        chk("m_done", done, mdone);
        chk("m_ovf", ovf, movf);
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim && mbusy; i++) tick();
        chk("idle_bound", busy, 0);
    endtask

    typedef struct {
        logic [31:0] acc;
        logic [15:0] d;
        logic        s;
    } vec_t;

    vec_t        tv[10];
    logic [16:0] ex[16];
    int          nv;

    initial begin
        tv[0] = '{32'h7FFFFFFF, 16'h0FFF, 1'b1};
        tv[1] = '{32'h80000000, 16'hF000, 1'b1};
        tv[2] = '{32'hFFFFFFFF, 16'hFFFF, 1'b0};
        tv[3] = '{32'h0007FF80, 16'h0FFF, 1'b0};
        tv[4] = '{32'h00004000, 16'h0080, 1'b0};
        tv[5] = '{32'hFFFFC000, 16'hFF80, 1'b0};
        tv[6] = '{32'h0007FFFF, 16'h0FFF, 1'b0};
        tv[7] = '{32'h00080000, 16'h0FFF, 1'b1};
        tv[8] = '{32'hFFF80000, 16'hF000, 1'b0};
        tv[9] = '{32'hFFF7FFFF, 16'hF000, 1'b1};

        // Reset with noisy inputs
        rst = 1; start = 1'($urandom); skip = 8'($urandom);
        len = 16'($urandom); acc_i = $urandom; out_ready = 1'($urandom);
        tick();
        start = 1'($urandom); acc_i = $urandom;
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_data", out_data, 0);
        rst = 0; start = 0; out_ready = 1;
        tick();

        // Basic burst: skip=2, len=4
        skip = 2; len = 4; acc_i = 32'h00004000; start = 1;
        tick();
        start = 0;
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) tick();
            chk("b_valid", out_valid, k >= 4 && k <= 7);
            chk("b_busy", busy, k <= 8);
            chk("b_done", done, k == 8);
            if (k >= 4 && k <= 7) begin
                chk("b_data", out_data, 16'h0080);
                chk("b_sat", out_sat, 0);
            end
        end

        // Conversion table
        for (int i = 0; i < 10; i++) begin
            acc_i = tv[i].acc; skip = 0; len = 1; start = 1;
            tick();
            start = 0;
            tick();
            chk("cv_valid", out_valid, 1);
            chk("cv_data", out_data, tv[i].d);
            chk("cv_sat", out_sat, tv[i].s);
            wait_idle(10);
        end

        // Backpressure overflow: 10 captures into 8 slots
        out_ready = 0; skip = 0; len = 10; start = 1;
        tick();
        start = 0;
        for (int k = 1; k <= 10; k++) begin
            acc_i = $urandom;
            ex[k-1] = conv(acc_i);
            tick();
            if (k == 8) chk("of_ovf0", ovf, 0);
            if (k == 9) chk("of_ovf1", ovf, 1);
        end
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            chk("of_valid", out_valid, 1);
            chk("of_data", out_data, ex[i][15:0]);
            tick();
        end
        chk("of_empty", out_valid, 0);
        chk("of_done", done, 1);
        tick();

        // Full plus pop on the same capture cycle
        out_ready = 0; skip = 0; len = 9; start = 1;
        tick();
        start = 0;
        for (int k = 1; k <= 9; k++) begin
            acc_i = $urandom;
            ex[k-1] = conv(acc_i);
            if (k == 9) out_ready = 1;
            tick();
        end
        chk("fp_ovf", ovf, 0);
        for (int i = 1; i <= 8; i++) begin
            chk("fp_valid", out_valid, 1);
            chk("fp_data", out_data, ex[i][15:0]);
            tick();
        end
        chk("fp_done", done, 1);
        tick();

        // len=0
        skip = 5; len = 0; start = 1;
        tick();
        start = 0;
        chk("l0_done", done, 1);
        chk("l0_valid", out_valid, 0);
        tick();
        chk("l0_busy", busy, 0);

        // start while busy is ignored
        skip = 3; len = 2; acc_i = 32'h00004000; start = 1;
        tick();
        skip = 0; len = 5;
        tick();
        start = 0; nv = 0;
        for (int i = 0; i < 30 && mbusy; i++) begin
            if (out_valid) nv++;
            tick();
        end
        chk("ign_words", nv, 2);

        // Reset mid-capture
        out_ready = 0; skip = 0; len = 6; start = 1;
        tick();
        start = 0;
        tick();
        tick();
        chk("rc_pre_valid", out_valid, 1);
        rst = 1;
        tick();
        rst = 0;
        chk("rc_valid", out_valid, 0);
        chk("rc_busy", busy, 0);
        chk("rc_done", done, 0);
        tick();

        // Normal burst after reset
        out_ready = 1; skip = 1; len = 3; acc_i = 32'h00004000; start = 1;
        tick();
        start = 0; nv = 0;
        for (int i = 0; i < 30 && mbusy; i++) begin
            if (out_valid) begin
                nv++;
                chk("nb_data", out_data, 16'h0080);
            end
            tick();
        end
        chk("nb_words", nv, 3);

        // Randomized run against the model
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom % 150) == 0;
            start = ($urandom % 6) == 0;
            skip  = 8'($urandom % 5);
            len   = 16'($urandom % 12);
            acc_i = $urandom;
            if ($urandom % 2 == 0) acc_i = {{11{acc_i[20]}}, acc_i[20:0]};
            out_ready = ($urandom % 3) != 0;
            tick();
        end
        rst = 0; start = 0; out_ready = 1;
        wait_idle(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
